// File: rtl/eaglesong_round_scheduler_if.sv
// eaglesong_round_scheduler_if
// Bundles the scheduler's handshake, permutation-core and status signals.
//   slave  : scheduler side (eaglesong_round_scheduler)
//   master : environment side (sponge logic + permutation core)
// Signals:
//   in_valid/in_ready/in_state      input state handshake (512-bit, word i = [32i+31:32i])
//   out_valid/out_ready/out_state   final state handshake
//   perm_state/perm_round/perm_start  request to the single-round core
//   perm_result/perm_done           core response
//   abort                           synchronous abort to IDLE
//   busy/err                        status (err only live with EAGLESONG_SCHED_TIMEOUT_EN)
interface eaglesong_round_scheduler_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_state;
  logic [511:0] perm_state;
  logic [5:0]   perm_round;
  logic         perm_start;
  logic [511:0] perm_result;
  logic         perm_done;
  logic         abort;
  logic         busy;
  logic         err;

  modport slave (
    input  in_valid, in_state, out_ready, perm_result, perm_done, abort,
    output in_ready, out_valid, out_state, perm_state, perm_round, perm_start, busy, err
  );

  modport master (
    output in_valid, in_state, out_ready, perm_result, perm_done, abort,
    input  in_ready, out_valid, out_state, perm_state, perm_round, perm_start, busy, err
  );
endinterface

// File: rtl/eaglesong_round_scheduler.sv
// eaglesong_round_scheduler
// Runs a full Eaglesong permutation by issuing NUM_ROUNDS single-round jobs to
// an external permutation core, feeding each round's result back as the next
// round's input, and presenting the final state on a valid/ready handshake.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      eaglesong_round_scheduler_if.slave (see interface file)
// Parameters:
//   NUM_ROUNDS      rounds per permutation (1..64, round counter is 6 bits)
//   TIMEOUT_CYCLES  per-round watchdog limit in WAIT cycles
// Build option:
//   EAGLESONG_SCHED_TIMEOUT_EN  enables the per-round watchdog, the ERR state
//                               and the sticky err flag; otherwise err is 0.
//
// state | meaning
// IDLE  | ready for a new input state (in_ready=1)
// ISSUE | one-cycle perm_start pulse for the current round
// WAIT  | holding perm_state/perm_round until perm_done
// DONE  | final state presented (out_valid=1) until out_ready
// ERR   | watchdog expired; left only by abort or reset (timeout build only)
module eaglesong_round_scheduler #(
  parameter int NUM_ROUNDS     = 43,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                          clk,
  input logic                          reset_n,
  eaglesong_round_scheduler_if.slave   bus
);

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

`ifdef EAGLESONG_SCHED_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  localparam int                TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_q, err_d;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3
  } state_e;
`endif

  state_e       state_q, state_d;
  logic [5:0]   round_q, round_d;
  logic [511:0] data_q, data_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      round_q <= '0;
      data_q  <= '0;
`ifdef EAGLESONG_SCHED_TIMEOUT_EN
      tmr_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      data_q  <= data_d;
`ifdef EAGLESONG_SCHED_TIMEOUT_EN
      tmr_q   <= tmr_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    data_d  = data_q;
`ifdef EAGLESONG_SCHED_TIMEOUT_EN
    tmr_d   = tmr_q;
    err_d   = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          data_d  = bus.in_state;
          round_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef EAGLESONG_SCHED_TIMEOUT_EN
        // Timer counts down over WAIT; reaching zero without perm_done means
        // TIMEOUT_CYCLES WAIT cycles have elapsed.
        tmr_d = TMR_LOAD;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.perm_done) begin
          data_d = bus.perm_result;
          if (round_q == LAST_ROUND) begin
            state_d = S_DONE;
          end else begin
            round_d = round_q + 6'd1;
            state_d = S_ISSUE;
          end
        end
`ifdef EAGLESONG_SCHED_TIMEOUT_EN
        else if (tmr_q == '0) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
`endif
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
`ifdef EAGLESONG_SCHED_TIMEOUT_EN
      S_ERR: begin
        state_d = S_ERR;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything, but keeps the data register and err flag.
    if (bus.abort) begin
      state_d = S_IDLE;
      round_d = '0;
      data_d  = data_q;
`ifdef EAGLESONG_SCHED_TIMEOUT_EN
      err_d   = err_q;
`endif
    end
  end

  // All outputs decode from registered state only.
  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.perm_start = (state_q == S_ISSUE);
  assign bus.busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign bus.perm_state = data_q;
  assign bus.out_state  = data_q;
  assign bus.perm_round = round_q;
`ifdef EAGLESONG_SCHED_TIMEOUT_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule
